// File: rtl/music_pkg.sv
// music_pkg: MIDI constants and player state encoding shared by the note player.
package music_pkg;
  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam int MIDI_MSG_BYTES = 3;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND_ON, GATE, SEND_OFF, REST} player_state_t;
endpackage

// File: rtl/note_sequence_player_if.sv
// note_sequence_player_if: valid/ready MIDI byte stream toward the UART transmitter.
interface note_sequence_player_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/midi_msg_serializer.sv
// midi_msg_serializer: sends a 3-byte MIDI message over valid/ready, pulses done on the last acceptance.
module midi_msg_serializer
  import music_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] msg,
  output logic        done,
  note_sequence_player_if.master tx
);
  localparam logic [1:0] LAST = 2'(MIDI_MSG_BYTES - 1);
  logic valid;
  logic [1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      valid <= 1'b1;
      cnt <= '0;
    end else if (valid && tx.tx_ready) begin
      valid <= cnt != LAST;
      cnt <= cnt == LAST ? '0 : cnt + 2'd1;
    end
  assign done = valid && tx.tx_ready && cnt == LAST;
  assign tx.tx_valid = valid;
  assign tx.tx_data = !valid ? 8'h00 : cnt == 2'd0 ? msg[23:16] : cnt == 2'd1 ? msg[15:8] : msg[7:0];
endmodule

// File: rtl/note_sequence_player.sv
// note_sequence_player: walks the note ROM, sending Note On, gate wait, Note Off, rest per step.
module note_sequence_player
  import music_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter logic [23:0] GATE_TICKS = 24'd6000000,
  parameter logic [23:0] REST_TICKS = 24'd6000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [N-1:0] index,
  input  logic [7:0]   note_in,
  input  logic [7:0]   velocity_in,
  note_sequence_player_if.master tx,
  output logic         busy
);
  player_state_t state, nxt;
  logic [23:0] timer;
  logic [7:0] note_r, vel_r;
  logic gate_end, rest_end, start, done, off;
  logic [23:0] msg;
  assign gate_end = state == GATE && timer == GATE_TICKS - 24'd1;
  assign rest_end = state == REST && timer == REST_TICKS - 24'd1;
  assign start = state == LATCH || gate_end;
  assign off = state == SEND_OFF;
  assign msg = {off ? MIDI_NOTE_OFF : MIDI_NOTE_ON, CHANNEL, note_r, off ? 8'h00 : vel_r};
  assign busy = state != IDLE;
  midi_msg_serializer u_ser (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .done(done), .tx(tx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = enable ? FETCH : IDLE;
      FETCH:    nxt = LATCH;
      LATCH:    nxt = SEND_ON;
      SEND_ON:  nxt = done ? GATE : SEND_ON;
      GATE:     nxt = gate_end ? SEND_OFF : GATE;
      SEND_OFF: nxt = done ? REST : SEND_OFF;
      REST:     nxt = rest_end ? (enable ? FETCH : IDLE) : REST;
      default:  nxt = IDLE;
    endcase
  end
  // Data bytes must keep bit 7 clear so they never look like a status byte.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      index <= '0;
      timer <= '0;
      note_r <= '0;
      vel_r <= '0;
    end else begin
      index <= rest_end ? index + N'(1) : index;
      timer <= (state == GATE && !gate_end) || (state == REST && !rest_end) ? timer + 24'd1 : '0;
      if (state == LATCH) begin
        note_r <= note_in & 8'h7f;
        vel_r <= velocity_in & 8'h7f;
      end
    end
endmodule

// File: tb/tb_note_sequence_player.sv
// tb_note_sequence_player: scoreboard bench for the note player, channel 0 and channel 9 instances.
module tb_note_sequence_player;
  typedef struct {logic [7:0] b; int gap; int idx;} exp_t;
  logic clk = 0, rst_n = 0, en0 = 0, en9 = 0, rdy0 = 1;
  logic [2:0] idx0, idx9;
  logic [7:0] n0, v0, n9, v9;
  logic busy0, busy9;
  logic [7:0] rom_n [8] = '{8'h3C, 8'h3E, 8'h3F, 8'h41, 8'h43, 8'hC5, 8'h47, 8'h48};
  logic [7:0] rom_v [8] = '{8'h64, 8'h50, 8'h40, 8'hC8, 8'h7F, 8'h00, 8'h30, 8'h64};
  logic [7:0] exp_n [8] = '{8'h3C, 8'h3E, 8'h3F, 8'h41, 8'h43, 8'h45, 8'h47, 8'h48};
  logic [7:0] exp_v [8] = '{8'h64, 8'h50, 8'h40, 8'h48, 8'h7F, 8'h00, 8'h30, 8'h64};
  exp_t q0[$], q9[$];
  exp_t e0, e9;
  int checks = 0, errors = 0, cyc = 0, last0 = 0, last9 = 0;
  logic stall0 = 0;
  logic [7:0] held0;
  note_sequence_player_if tx0();
  note_sequence_player_if tx9();
  assign tx0.tx_ready = rdy0;
  assign tx9.tx_ready = 1'b1;
  note_sequence_player #(.N(3), .CHANNEL(4'd0), .GATE_TICKS(24'd4), .REST_TICKS(24'd4)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .index(idx0), .note_in(n0), .velocity_in(v0),
    .tx(tx0), .busy(busy0)
  );
  note_sequence_player #(.N(3), .CHANNEL(4'd9), .GATE_TICKS(24'd1), .REST_TICKS(24'd1)) dut9 (
    .clk(clk), .rst_n(rst_n), .enable(en9), .index(idx9), .note_in(n9), .velocity_in(v9),
    .tx(tx9), .busy(busy9)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    n0 <= rom_n[idx0];
    v0 <= rom_v[idx0];
    n9 <= rom_n[idx9];
    v9 <= rom_v[idx9];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) stall0 = 0;
    else begin
      if (stall0) begin
        chk("hold0_valid", tx0.tx_valid, 1);
        chk("hold0_data", tx0.tx_data, held0);
      end
      if (tx0.tx_valid && tx0.tx_ready) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra0: got byte %0h expected none at cycle %0d", tx0.tx_data, cyc);
        end else begin
          e0 = q0.pop_front();
          chk("byte0", tx0.tx_data, e0.b);
          if (e0.gap >= 0) chk("gap0", cyc - last0, e0.gap);
          if (e0.idx >= 0) chk("index0", idx0, e0.idx);
        end
        last0 = cyc;
      end
      stall0 = tx0.tx_valid && !tx0.tx_ready;
      held0 = tx0.tx_data;
    end
  end
  always @(negedge clk) begin
    if (rst_n && tx9.tx_valid) begin
      if (q9.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra9: got byte %0h expected none at cycle %0d", tx9.tx_data, cyc);
      end else begin
        e9 = q9.pop_front();
        chk("byte9", tx9.tx_data, e9.b);
        if (e9.gap >= 0) chk("gap9", cyc - last9, e9.gap);
        if (e9.idx >= 0) chk("index9", idx9, e9.idx);
      end
      last9 = cyc;
    end
  end
  task automatic push0(input int s, input int g0, input int g1);
    q0.push_back('{8'h90, g0, s % 8});
    q0.push_back('{exp_n[s % 8], g1, -1});
    q0.push_back('{exp_v[s % 8], 1, -1});
    q0.push_back('{8'h80, 5, -1});
    q0.push_back('{exp_n[s % 8], 1, -1});
    q0.push_back('{8'h00, 1, -1});
  endtask
  task automatic push9(input int s, input int g0);
    q9.push_back('{8'h99, g0, s % 8});
    q9.push_back('{exp_n[s % 8], 1, -1});
    q9.push_back('{exp_v[s % 8], 1, -1});
    q9.push_back('{8'h89, 2, -1});
    q9.push_back('{exp_n[s % 8], 1, -1});
    q9.push_back('{8'h00, 1, -1});
  endtask
  task automatic wait_q0(input int n);
    for (int i = 0; i < 3000 && q0.size() > n; i++) @(posedge clk);
    chk("wait_q0", q0.size() <= n, 1);
  endtask
  task automatic wait_q9(input int n);
    for (int i = 0; i < 3000 && q9.size() > n; i++) @(posedge clk);
    chk("wait_q9", q9.size() <= n, 1);
  endtask
  task automatic wait_idle0();
    for (int i = 0; i < 200 && busy0; i++) @(posedge clk);
    #1 chk("idle0_busy", busy0, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tx0.tx_valid, 0);
    chk("rst_data", tx0.tx_data, 0);
    chk("rst_index", idx0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_busy9", busy9, 0);
    @(negedge clk) rst_n = 1;
    en9 = 1;
    push9(0, -1);
    push9(1, 4);
    wait_q9(3);
    en9 = 0;
    wait_q9(0);
    for (int i = 0; i < 100 && busy9; i++) @(posedge clk);
    #1 chk("idle9_busy", busy9, 0);
    chk("idle9_index", idx9, 2);
    en0 = 1;
    push0(0, -1, 1);
    for (int s = 1; s <= 8; s++) push0(s, 7, 1);
    wait_q0(3);
    en0 = 0;
    wait_q0(0);
    wait_idle0();
    chk("wrap_index", idx0, 1);
    en0 = 1;
    push0(1, -1, 1);
    push0(2, 7, 1);
    wait_q0(3);
    en0 = 0;
    wait_q0(0);
    wait_idle0();
    chk("drop_index", idx0, 3);
    chk("drop_valid", tx0.tx_valid, 0);
    en0 = 1;
    push0(3, -1, 6);
    wait_q0(5);
    #1 rdy0 = 0;
    repeat (5) @(posedge clk);
    #1 rdy0 = 1;
    wait_q0(3);
    en0 = 0;
    wait_q0(0);
    wait_idle0();
    chk("bp_index", idx0, 4);
    en0 = 1;
    q0.push_back('{8'h90, -1, 4});
    wait_q0(0);
    #1 rdy0 = 0;
    chk("pre_rst_valid", tx0.tx_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", tx0.tx_valid, 0);
    chk("mid_rst_data", tx0.tx_data, 0);
    chk("mid_rst_index", idx0, 0);
    chk("mid_rst_busy", busy0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) begin
      rst_n = 1;
      rdy0 = 1;
    end
    push0(0, -1, 1);
    wait_q0(3);
    en0 = 0;
    wait_q0(0);
    wait_idle0();
    chk("post_rst_index", idx0, 1);
    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
